// File: rtl/uart_tx_frame.sv
// UART transmit framer: turns baud_clk rising edges into one-cycle ticks and
// shifts out start, data (LSB first), optional parity and one or two stop bits.
module uart_tx_frame #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_clk,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        parity_type,
  input  logic              stop_bits,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_e;

  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  state_e            state_q;
  logic              baud_q;
  logic              tick;
  logic [DATA_W-1:0] shift_q;
  logic [2:0]        cnt_q;
  logic              parEn_q;
  logic              parBit_q;
  logic              stop2_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;

  // baud_clk is already registered upstream in this clock domain, so one flop
  // is enough to find its rising edges.
  assign tick = baud_clk & ~baud_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_q <= 1'b0;
    end else begin
      baud_q <= baud_clk;
    end
  end

  // Every line change happens on a tick; accept itself never consumes a tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= 3'd0;
      parEn_q  <= 1'b0;
      parBit_q <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_start) begin
            state_q  <= ARMED;
            busy_q   <= 1'b1;
            shift_q  <= data_in;
            parEn_q  <= parity_type[0] ^ parity_type[1];
            parBit_q <= (parity_type == 2'b01) ? ~^data_in : ^data_in;
            stop2_q  <= stop_bits;
          end
        end
        ARMED: begin
          if (tick) begin
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
            cnt_q   <= 3'd0;
          end
        end
        DATA: begin
          if (tick) begin
            if (cnt_q == LAST_BIT) begin
              if (parEn_q) begin
                state_q <= PARITY;
                tx_q    <= parBit_q;
              end else begin
                state_q <= STOP1;
                tx_q    <= 1'b1;
              end
            end else begin
              cnt_q   <= cnt_q + 3'd1;
              tx_q    <= shift_q[1];
              shift_q <= shift_q >> 1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state_q <= STOP1;
            tx_q    <= 1'b1;
          end
        end
        STOP1: begin
          if (tick) begin
            if (stop2_q) begin
              state_q <= STOP2;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
            tx_q <= 1'b1;
          end
        end
        STOP2: begin
          if (tick) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

UART transmit framer that sits directly downstream of the baud generator. It consumes the generator's `baud_clk` square wave and converts it, inside the `clk` domain, into a one-cycle bit tick. It latches a parallel byte plus frame configuration and shifts out start, data (LSB first), optional parity and one or two stop bits on the serial line `tx`. It reports `busy` while a frame is in flight and pulses `done` once the frame completes.

## Interface
- `DATA_W`, default 8: number of data bits per frame; legal range 5–8.
- `clk` input 1: system clock; the same clock that drives the baud generator.
- `rst` input 1: reset, asynchronous, active-low.
- `baud_clk` input 1: square wave from the baud generator. It is registered in the `clk` domain, so no synchronizer is required.
- `tx_start` input 1: request to send a frame. It is sampled only while `busy` = 0.
- `data_in` input `DATA_W`: frame payload, latched at accept.
- `parity_type` input 2: 00 none, 01 odd, 10 even, 11 none. Latched at accept.
- `stop_bits` input 1: 0 selects one stop bit, 1 selects two. Latched at accept.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high from the cycle after accept until frame end.
- `done` output 1: single-`clk` pulse at frame end.

## Operation
- Tick generation:
  - `baud_q` is a register holding `baud_clk` from the previous cycle.
  - `tick` = `baud_clk` & ~`baud_q`, a combinational pulse one `clk` wide per rising edge of `baud_clk`.
  - One bit period is the interval between consecutive ticks.
- Accept:
  - Accept occurs when `tx_start` = 1 and `busy` = 0 on a `clk` edge.
  - On accept, latch `data_in` into the shift register, along with `parity_type` and `stop_bits`.
  - Also compute and latch the parity bit at accept: odd = ~^data, even = ^data.
  - `tx_start` while `busy` = 1 is ignored; no queueing.
- State machine (state register plus bit counter, 3 bits):
  - IDLE: `tx` = 1. On accept, go to ARMED and set `busy` = 1.
  - ARMED: `tx` = 1. On `tick`, go to START and set `tx` to 0.
  - START: on `tick`, go to DATA and drive `tx` = data[0]; bit counter = 0.
  - DATA: on each `tick`, the counter increments and `tx` = data[counter].
    - After bit `DATA_W`-1 completes, the next `tick` goes to PARITY (`tx` = parity bit) when parity is enabled.
    - Otherwise it goes to STOP1 (`tx` = 1).
  - PARITY: on `tick`, go to STOP1 with `tx` = 1.
  - STOP1: on `tick`, go to STOP2 if `stop_bits` = 1; otherwise finish.
  - STOP2: on `tick`, finish.
  - Finish: state goes to IDLE, `tx` stays 1, `busy` goes to 0, and `done` = 1 for exactly one cycle.
- Line changes:
  - `tx` changes only on tick cycles and each bit lasts exactly one bit period.
  - `tx` is registered, so there is no combinational glitch.
- Back-to-back frames: accept is legal in the same cycle `done` is high. The next frame waits in ARMED for the following tick.
- Input stability: the latched config and data are immune to input changes after accept.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `done` = 0, state = IDLE, counter = 0, `baud_q` = 0.
- Reset behaviour:
  - Reset is asynchronous. Asserting it mid-frame forces `tx` high immediately and aborts the frame with no `done` pulse.
  - After release, the first `baud_clk` rising edge seen relative to `baud_q` = 0 may produce a tick. This is harmless because the block is in IDLE.
- `busy` rises on the clk edge of accept (visible the next cycle).
- Start-bit latency: `tx` falls on the edge of the first tick after accept, so latency is 0 to one bit period plus 1 `clk`.
- Frame length in bit periods: 1 + `DATA_W` + (parity enabled ? 1 : 0) + (1 or 2 stop bits). With 8N1 that is 10 periods, and with 8E2 it is 12.
- `done` and the `busy` fall occur on the same edge, which is the tick edge ending the last stop bit.
- A tick landing in the same cycle as accept is not consumed: the state is still IDLE in that cycle, so the start bit waits for the next tick.
- `baud_clk` with any high/low duty cycle is legal; only rising edges matter.

## Test plan
- Basic 8N1 frame:
  - Stimulus: bench drives `baud_clk` with a 20-clk period; `data_in` = 8'hA5, `parity_type` = 00, `stop_bits` = 0, `tx_start` pulsed.
  - Response: `tx` sequence per tick is 0,1,0,1,0,0,1,0,1,1, i.e. start, 10100101 sent LSB first, stop. Each level lasts 20 clk, and `done` pulses once after 10 ticks.
- Parity frames with two stop bits:
  - Stimulus: 8'h03 with even parity and `stop_bits` = 1.
  - Response: parity bit 0, followed by two stop periods high; 12 ticks total. The same data with odd parity yields parity bit 1.
- Ignored request:
  - Stimulus: pulse `tx_start` with 8'h55 during the middle of a frame carrying 8'hFF.
  - Response: only the 8'hFF frame appears on `tx`, and `busy` stays high continuously.
- Back-to-back frames:
  - Stimulus: assert `tx_start` in the `done` cycle with 8'h0F.
  - Response: the second frame's start bit begins exactly one tick after the first frame ends, and `tx` stays high between frames.
- Reset mid-frame:
  - Stimulus: drop `rst` during data bit 3.
  - Response: `tx` = 1 and `busy` = 0 immediately, and no `done` pulse. After release a new frame transmits correctly.
- Integration with the baud generator:
  - Stimulus: connect the baud generator with `baud_rate` = 2'b11.
  - Response: the bit period measures 3906 clk.
